serial_subtractor_controller: RTL and testbench
===============================================

SERIAL_SUBTRACTOR_CONTROLLER -- requirements
Module: serial_subtractor_controller

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (legal range 1..32).
REQ-002 SHALL have ports, one per line:
  clk    input   1      single clock, all state on rising edge
  rst_n  input   1      asynchronous active-low reset
  start  input   1      request; sampled only in IDLE or DONE
  a      input   WIDTH  minuend, captured on the accepting edge
  b      input   WIDTH  subtrahend, captured on the accepting edge
  bin    input   1      borrow-in, captured on the accepting edge
  busy   output  1      high while in RUN
  done   output  1      one-cycle pulse, result valid
  d      output  WIDTH  difference a-b-bin mod 2^WIDTH
  bo     output  1      final borrow-out
  ovf    output  1      signed overflow (SERIAL_SUB_OVF_EN only)
REQ-003 SHALL use one clock, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 SHALL compute a-b-bin bit-serially, LSB first, through exactly one 1-bit full-subtractor cell (d=x^y^br, bo=(~x&y)|(~x&br)|(y&~(x^br))... i.e. standard full-subtractor truth table).
REQ-005 SHALL implement FSM states IDLE, RUN, DONE.
REQ-006 IDLE: start=1 at edge -> load a, b, bin into shift/borrow registers, clear bit counter, go RUN; start=0 -> stay.
REQ-007 RUN: each edge processes current LSB, shifts difference bit into result MSB, latches cell borrow, increments counter; after WIDTH edges -> DONE.
REQ-008 DONE: done=1 for exactly that one cycle; start=1 -> reload and go RUN (back-to-back); else -> IDLE.
REQ-009 Latency: start accepted at edge k -> done high during cycle after edge k+WIDTH; throughput one op per WIDTH+1 cycles.
REQ-010 start during RUN SHALL be ignored; a, b, bin changes during RUN SHALL NOT affect the result.
REQ-011 d and bo SHALL hold last result from DONE until the next accepting edge; contents during RUN unspecified.
REQ-012 bo SHALL be 1 iff unsigned a < b+bin.
REQ-013 WIDTH=1 SHALL work (RUN lasts one cycle); counter width SHALL be clog2(WIDTH+1).

Reset
REQ-014 rst_n low SHALL immediately force IDLE, busy=0, done=0, d=0, bo=0, ovf=0, counter=0.
REQ-015 Reset mid-RUN SHALL abort the operation with no done pulse; first start after release SHALL behave as from cold reset.

Configuration
REQ-016 Macro SERIAL_SUB_OVF_EN defined: ovf = borrow into MSB XOR borrow out of MSB, registered with bo, same hold rules.
REQ-017 Macro undefined: ovf port absent, no extra flops.

Structure
REQ-018 Shared package SHALL hold FSM state enum (IDLE/RUN/DONE) and default width constant.
REQ-019 1-bit cell SHALL be a separate combinational sub-module fs_cell (inputs x, y, br; outputs d, bo), instantiated once.

Verification
REQ-020 WIDTH=8: a=0x05,b=0x03,bin=0 start at edge 0 -> done in cycle after edge 8, d=0x02, bo=0, busy high edges 1..8.
REQ-021 a=0x00,b=0x01,bin=0 -> d=0xFF, bo=1; a=0x00,b=0x00,bin=1 -> d=0xFF, bo=1.
REQ-022 SERIAL_SUB_OVF_EN: a=0x80,b=0x01,bin=0 -> d=0x7F, bo=0, ovf=1; a=0x7F,b=0xFF -> d=0x80, bo=1, ovf=1.
REQ-023 rst_n low at edge 4 of RUN -> outputs zero asynchronously, no done; new start 0x10-0x01 -> d=0x0F.
REQ-024 start held high continuously with changing a/b during RUN -> results match operands at accept edges, done every 9 cycles.
REQ-025 WIDTH=1 exhaustive all 8 (a,b,bin) -> d, bo match full-subtractor truth table, done one cycle after RUN.

Source files
------------

// File: rtl/serial_subtractor_controller_pkg.sv
// rtl/serial_subtractor_controller_pkg.sv - shared FSM state type and default width for the serial subtractor
package serial_subtractor_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_controller_fs_cell.sv
// rtl/serial_subtractor_controller_fs_cell.sv - combinational 1-bit full-subtractor cell (module fs_cell)
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic br,
    output logic d,
    output logic bo
);

    // Difference is the parity of all three inputs; borrow when x is smaller than y+br.
    always_comb begin
        d  = x ^ y ^ br;
        bo = (~x & y) | (~x & br) | (y & br);
    end

endmodule

// File: rtl/serial_subtractor_controller.sv
// rtl/serial_subtractor_controller.sv - bit-serial a-b-bin subtractor controller; optional ovf output under SERIAL_SUB_OVF_EN
module serial_subtractor_controller
    import serial_subtractor_controller_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_bo;
    logic             accept;
    logic             last;
    logic [WIDTH:0]   res_ext;

    // The only arithmetic in the design: one bit per RUN cycle, LSB first.
    fs_cell u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .br (br),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // Handshake decode; the borrow register doubles as the final borrow-out.
    always_comb begin
        accept  = start && ((state == IDLE) || (state == DONE));
        last    = (state == RUN) && (cnt == LAST_CNT);
        res_ext = {cell_d, res};
        busy    = (state == RUN);
        done    = (state == DONE);
        d       = res;
        bo      = br;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept from IDLE or DONE, leave RUN after WIDTH bits.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load operands on accept, shift one bit per RUN cycle, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= res_ext[WIDTH:1];
            br   <= cell_bo;
            cnt  <= cnt + CW'(1);
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_r;

    // Signed overflow: borrow into the MSB differs from borrow out of it; captured on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (last) begin
            ovf_r <= br ^ cell_bo;
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor_controller.sv
// tb/tb_serial_subtractor_controller.sv - directed bench for serial_subtractor_controller (WIDTH 8 and 1)
module tb_serial_subtractor_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       bo;
    logic       start1;
    logic       a1;
    logic       b1;
    logic       bin1;
    logic       busy1;
    logic       done1;
    logic       d1;
    logic       bo1;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
    logic       ovf1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_subtractor_controller #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bo    (bo)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_subtractor_controller #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .d     (d1),
        .bo    (bo1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ovf;
    } vec_t;

    vec_t vecs[11];
    vec_t b2b[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One WIDTH=8 operation; operands are scrambled right after the accepting edge.
    task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                        output int lat, output logic got);
        @(negedge clk);
        a = va; b = vb; bin = vbin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~va; b = ~vb; bin = ~vbin;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) lat++;
        end
    endtask

    task automatic run1(input logic va, input logic vb, input logic vbin,
                        output int lat, output logic got);
        @(negedge clk);
        a1 = va; b1 = vb; bin1 = vbin; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0; a1 = ~va; b1 = ~vb; bin1 = ~vbin;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done1) begin
                got = 1'b1;
                break;
            end
            if (busy1) lat++;
        end
    endtask

    initial begin
        int         lat;
        logic       got;
        int         done_cnt;
        int         idx;
        int         prev_cyc;
        logic [7:0] td_tab;
        logic [7:0] tb_tab;
        logic [2:0] sel;

        vecs[0]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4]  = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[5]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[6]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[7]  = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
        vecs[8]  = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1};
        vecs[9]  = '{8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1, 1'b0};

        b2b[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        b2b[1] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        b2b[2] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_d",    32'(d),    32'h0);
        check("reset_bo",   32'(bo),   32'h0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf",  32'(ovf),  32'h0);
`endif
        rst_n = 1'b1;

        // Table-driven single operations at WIDTH=8.
        for (int i = 0; i < 11; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].bin, lat, got);
            check($sformatf("v%0d_done", i), 32'(got), 32'h1);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'd8);
            check($sformatf("v%0d_d", i), 32'(d), 32'(vecs[i].d));
            check($sformatf("v%0d_bo", i), 32'(bo), 32'(vecs[i].bo));
            check($sformatf("v%0d_busy_in_done", i), 32'(busy), 32'h0);
`ifdef SERIAL_SUB_OVF_EN
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
`endif
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), 32'(done), 32'h0);
            check($sformatf("v%0d_hold_d", i), 32'(d), 32'(vecs[i].d));
            check($sformatf("v%0d_hold_bo", i), 32'(bo), 32'(vecs[i].bo));
        end

        // Reset in the middle of RUN: outputs clear at once and no done appears.
        @(negedge clk);
        a = 8'h77; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_d",    32'(d),    32'h0);
        check("midrst_bo",   32'(bo),   32'h0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'h0);
        run8(8'h10, 8'h01, 1'b0, lat, got);
        check("postrst_done", 32'(got), 32'h1);
        check("postrst_lat", 32'(lat), 32'd8);
        check("postrst_d", 32'(d), 32'h0F);
        check("postrst_bo", 32'(bo), 32'h0);

        // Back-to-back with start held high and junk operands during RUN.
        @(negedge clk);
        @(negedge clk);
        a = b2b[0].a; b = b2b[0].b; bin = b2b[0].bin; start = 1'b1;
        idx = 0;
        prev_cyc = -1;
        for (int cyc = 0; cyc < 60 && idx < 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                check($sformatf("b2b%0d_d", idx), 32'(d), 32'(b2b[idx].d));
                check($sformatf("b2b%0d_bo", idx), 32'(bo), 32'(b2b[idx].bo));
`ifdef SERIAL_SUB_OVF_EN
                check($sformatf("b2b%0d_ovf", idx), 32'(ovf), 32'(b2b[idx].ovf));
`endif
                if (prev_cyc >= 0) check($sformatf("b2b%0d_gap", idx), 32'(cyc - prev_cyc), 32'd9);
                prev_cyc = cyc;
                idx++;
                if (idx < 3) begin
                    a = b2b[idx].a; b = b2b[idx].b; bin = b2b[idx].bin;
                end else begin
                    start = 1'b0;
                end
            end else begin
                a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(idx), 32'd3);

        // WIDTH=1 exhaustive against the full-subtractor truth table, index {x,y,bin}.
        td_tab = 8'b1001_0110;
        tb_tab = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            run1(sel[2], sel[1], sel[0], lat, got);
            check($sformatf("w1_%0d_done", i), 32'(got), 32'h1);
            check($sformatf("w1_%0d_lat", i), 32'(lat), 32'd1);
            check($sformatf("w1_%0d_d", i), 32'(d1), 32'(td_tab[i]));
            check($sformatf("w1_%0d_bo", i), 32'(bo1), 32'(tb_tab[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
